// File: rtl/line_pkg.sv
// -----------------------------------------------------------------------------
// line_pkg
//   Shared definitions for the bottle line sequencer: state encodings (also
//   shown on the state LEDs), default timing constants and a small helper
//   used to size the shared timer.
// -----------------------------------------------------------------------------
package line_pkg;

   localparam int LINE_STATE_W = 3;

   // Explicit codes: the LED panel decodes these values directly.
   typedef enum logic [LINE_STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_ADVANCE   = 3'd1,
      ST_REQUEST   = 3'd2,
      ST_WAIT_FILL = 3'd3,
      ST_RELEASE   = 3'd4,
      ST_FAULT     = 3'd5
   } line_state_t;

   // Conveyor-on cycles needed to move a filled bottle clear of the nozzle.
   localparam int REL_CYCLES_DEF     = 3;
   // Longest acceptable fill; the filler itself needs 4 cycles.
   localparam int TIMEOUT_CYCLES_DEF = 8;
   localparam int CNT_W_DEF          = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/line_timer.sv
// -----------------------------------------------------------------------------
// line_timer
//   Up-counter cleared on state entry, with a terminal-count compare. The
//   counter holds at all-ones rather than wrapping, so an unbounded wait can
//   never alias back onto a small terminal value.
// Ports
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   clr_i   in   restart counting from 0 on the next cycle
//   term_i  in   terminal value to compare against
//   tc_o    out  1 while the count equals term_i
// -----------------------------------------------------------------------------
module line_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic [W-1:0] term_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      // NOTE: default assignment first so every path drives cnt_d; no latch.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: reset is sampled on the clock edge only, so it is checked inside the clocked block.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: non-blocking assignments for all clocked state.
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/bottle_line_controller.sv
// -----------------------------------------------------------------------------
// bottle_line_controller
//   Initiator side of the start-fill / fill-done handshake with the bottle
//   filler. Runs the conveyor until a bottle arrives under the nozzle, pulses
//   startfill, waits for lleno_flag, moves the filled bottle out and counts it.
//   Moore machine: every output is decoded from registered state only.
//
// Configuration macro
//   FILL_TIMEOUT_EN  defined   : a fill that takes TIMEOUT_CYCLES cycles
//                                without lleno_flag enters a sticky FAULT state
//                                cleared by fault_clr.
//                    undefined : WAIT_FILL waits indefinitely, fault stays 0,
//                                fault_clr is ignored.
//
// Ports
//   clk              in   system clock (1 Hz tick domain shared with filler)
//   rst              in   synchronous active-high reset
//   run_en           in   operator run switch (level)
//   bottle_present   in   nozzle position sensor, 1 = bottle present
//   fault_clr        in   clears FAULT (level, looked at in FAULT only)
//   lleno_flag       in   filler done, 1-cycle pulse
//   startfill        out  fill request, 1-cycle pulse
//   conveyor_on      out  conveyor motor enable
//   bottle_count     out  bottles filled since reset, saturating
//   fault            out  fill-timeout fault, sticky
//   state_indicator  out  current state code for the LED panel
// -----------------------------------------------------------------------------
module bottle_line_controller
   import line_pkg::*;
#(
   parameter int REL_CYCLES     = REL_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    run_en,
   input  logic                    bottle_present,
   input  logic                    fault_clr,
   input  logic                    lleno_flag,
   output logic                    startfill,
   output logic                    conveyor_on,
   output logic [CNT_W-1:0]        bottle_count,
   output logic                    fault,
   output logic [LINE_STATE_W-1:0] state_indicator
);

   // One timer serves both RELEASE and WAIT_FILL, sized for the longer.
   localparam int TMR_W = $clog2(max_int(REL_CYCLES, TIMEOUT_CYCLES)) + 1;

   // Kept as a plain vector so the unused codes 6/7 are representable and
   // recover through the default branch.
   logic [LINE_STATE_W-1:0] state_q;
   logic [LINE_STATE_W-1:0] state_d;
   logic [CNT_W-1:0]        count_q;
   logic [CNT_W-1:0]        count_d;
   logic                    bp_q;
   logic                    arrival;

   logic                    tmr_clr;
   logic                    tmr_tc;
   logic [TMR_W-1:0]        tmr_term;
   logic                    timeout_hit;

   // A bottle counts only on the sensor's rising edge, so one already sitting
   // under the nozzle when ADVANCE is entered does not start a second fill.
   assign arrival = bottle_present & ~bp_q;

   // The terminal value follows the state the timer is currently timing.
   assign tmr_term = (state_q == ST_WAIT_FILL) ? TMR_W'(TIMEOUT_CYCLES - 1)
                                               : TMR_W'(REL_CYCLES - 1);

   // Clearing whenever the state changes gives "timer = 0 on entry".
   assign tmr_clr = (state_d != state_q);

   line_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (tmr_clr),
      .term_i (tmr_term),
      .tc_o   (tmr_tc)
   );

`ifdef FILL_TIMEOUT_EN
   assign timeout_hit = tmr_tc;
`else
   logic unused_fault_clr;
   assign timeout_hit      = 1'b0;
   assign unused_fault_clr = fault_clr;
`endif

   // -------------------------------------------------------------------------
   // Next-state and counter logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         ST_IDLE: begin
            if (run_en) state_d = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            // An arriving bottle is serviced even if the operator stops now.
            if (arrival)      state_d = ST_REQUEST;
            else if (!run_en) state_d = ST_IDLE;
         end
         ST_REQUEST: begin
            state_d = ST_WAIT_FILL;
         end
         ST_WAIT_FILL: begin
            // run_en is deliberately ignored: an issued fill always completes.
            // lleno_flag is tested first so it wins over a coincident timeout.
            if (lleno_flag) begin
               state_d = ST_RELEASE;
               if (count_q != '1) count_d = count_q + 1'b1;
            end else if (timeout_hit) begin
               state_d = ST_FAULT;
            end
         end
         ST_RELEASE: begin
            if (tmr_tc) state_d = run_en ? ST_ADVANCE : ST_IDLE;
         end
`ifdef FILL_TIMEOUT_EN
         ST_FAULT: begin
            if (fault_clr) state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         bp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bp_q    <= bottle_present;
      end
   end

   // -------------------------------------------------------------------------
   // Moore output decode
   // -------------------------------------------------------------------------
   always_comb begin
      startfill   = 1'b0;
      conveyor_on = 1'b0;
      fault       = 1'b0;
      case (state_q)
         ST_ADVANCE: conveyor_on = 1'b1;
         ST_REQUEST: startfill   = 1'b1;
         ST_RELEASE: conveyor_on = 1'b1;
`ifdef FILL_TIMEOUT_EN
         ST_FAULT:   fault       = 1'b1;
`endif
         default: begin
            startfill   = 1'b0;
            conveyor_on = 1'b0;
            fault       = 1'b0;
         end
      endcase
   end

   assign bottle_count    = count_q;
   assign state_indicator = state_q;

endmodule
